// File: rtl/ch0re_types.sv
// Shared types and constants for the ch0re instruction-fetch stage.
package ch0re_types;

   localparam logic [31:0] FETCH_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [63:0] word_align(input logic [63:0] addr);
      return {addr[63:2], 2'b00};
   endfunction

endpackage

// File: rtl/ch0re_fetch_fifo.sv
// In-order circular buffer of fetched {pc, instr} entries; flush empties it in one cycle.
module ch0re_fetch_fifo
   import ch0re_types::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  fetch_entry_t  push_data,
   input  logic          pop,
   input  logic          flush,
   output fetch_entry_t  head,
   output logic [CW-1:0] count
);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop, full, empty;
   fetch_entry_t  mem_q [DEPTH];

   always_comb begin
      full     = (count_q == CW'(DEPTH));
      empty    = (count_q == '0);
      do_pop   = pop & ~flush & ~empty;
      // A full buffer may still accept when the head leaves in the same cycle.
      do_push  = push & ~flush & (~full | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/ch0re_ifetch.sv
// Instruction-fetch stage: PC generation, credit-limited imem requests,
// stale-response dropping after redirects, and the fetch buffer feeding decode.
module ch0re_ifetch
   import ch0re_types::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          FB_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        o_imem_req,
   output logic [63:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   input  logic        i_redirect,
   input  logic [63:0] i_redirect_pc,
   input  logic        i_stall,
   output logic        o_valid,
   output logic [31:0] o_instr,
   output logic [63:0] o_pc
);

   localparam int CW = $clog2(FB_DEPTH) + 1;
   localparam int SW = CW + 2;

   logic [63:0]   fetch_pc_q, fetch_pc_d;
   logic [63:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0] live_cnt_q, live_cnt_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   logic [CW-1:0] occ;
   logic [SW-1:0] in_use;
   logic          fire, rsp_drop, rsp_push, pop;
   fetch_entry_t  head, push_entry;

   always_comb begin
      // Every buffer slot is reserved from grant until pop, so overflow is impossible.
      in_use      = SW'(live_cnt_q) + SW'(drop_cnt_q) + SW'(occ);
      o_imem_req  = rst_n & ~i_redirect & (in_use < SW'(FB_DEPTH));
      o_imem_addr = word_align(fetch_pc_q);
      fire        = o_imem_req & i_imem_gnt;
      rsp_drop    = i_imem_rvalid & (drop_cnt_q != '0);
      rsp_push    = i_imem_rvalid & ~rsp_drop & ~i_redirect;
      push_entry  = '{pc: resp_pc_q, instr: i_imem_rdata};
      o_valid     = rst_n & ~i_redirect & (occ != '0);
      pop         = o_valid & ~i_stall;
      o_instr     = o_valid ? head.instr : FETCH_NOP;
      o_pc        = o_valid ? head.pc : 64'h0;
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      live_cnt_d = live_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (i_redirect) begin
         // Everything still outstanding becomes stale; a response arriving now retires one.
         fetch_pc_d = word_align(i_redirect_pc);
         resp_pc_d  = word_align(i_redirect_pc);
         live_cnt_d = '0;
         drop_cnt_d = drop_cnt_q + live_cnt_q + CW'(fire) - CW'(i_imem_rvalid);
      end else begin
         if (fire)     fetch_pc_d = fetch_pc_q + 64'd4;
         if (rsp_push) resp_pc_d  = resp_pc_q + 64'd4;
         if (rsp_drop) drop_cnt_d = drop_cnt_q - 1'b1;
         live_cnt_d = live_cnt_q + CW'(fire) - CW'(rsp_push);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         live_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         live_cnt_q <= live_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   ch0re_fetch_fifo #(
      .DEPTH (FB_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rsp_push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (i_redirect),
      .head      (head),
      .count     (occ)
   );

endmodule

// File: tb/tb_ch0re_ifetch.sv
// Scoreboard bench for ch0re_ifetch: behavioural imem and fetch model, expected entries queued at response time.
module tb_ch0re_ifetch;
   import ch0re_types::*;

   localparam logic [63:0] RESET_PC = 64'h0;
   localparam int          FB_DEPTH = 2;

   logic        clk;
   logic        rst_n;
   logic        o_imem_req;
   logic [63:0] o_imem_addr;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic        i_redirect;
   logic [63:0] i_redirect_pc;
   logic        i_stall;
   logic        o_valid;
   logic [31:0] o_instr;
   logic [63:0] o_pc;

   ch0re_ifetch #(
      .RESET_PC (RESET_PC),
      .FB_DEPTH (FB_DEPTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_gnt    (i_imem_gnt),
      .i_imem_rvalid (i_imem_rvalid),
      .i_imem_rdata  (i_imem_rdata),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .i_stall       (i_stall),
      .o_valid       (o_valid),
      .o_instr       (o_instr),
      .o_pc          (o_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   // stimulus controls for the next cycle
   logic        rst_v, stall_v, redir_v, gnt_en, rv_en;
   logic [63:0] redir_pc_v;

   // reference model
   logic [63:0]  m_fpc, m_rpc, seq_pc;
   int           m_live, m_drop;
   fetch_entry_t fbq[$];
   logic [63:0]  mq_addr[$];
   int           mq_cyc[$];
   int           first_gnt, first_valid;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return a[31:0] ^ 32'h5A5A_0003;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic step();
      logic        exp_req, exp_valid, fire, rv;
      logic [63:0] rv_addr;
      rv      = rv_en && (mq_addr.size() > 0) && (mq_cyc[0] < cyc);
      rv_addr = rv ? mq_addr[0] : 64'h0;
      i_imem_gnt    = gnt_en;
      i_imem_rvalid = rv;
      i_imem_rdata  = rv ? mem_word(rv_addr) : 32'hDEAD_BEEF;
      rst_n         = rst_v;
      i_stall       = stall_v;
      i_redirect    = redir_v;
      i_redirect_pc = redir_pc_v;
      #1;
      exp_req   = rst_v && !redir_v && (m_live + m_drop + fbq.size() < FB_DEPTH);
      exp_valid = rst_v && !redir_v && (fbq.size() > 0);
      chk("imem_req", 64'(o_imem_req), 64'(exp_req));
      if (exp_req) chk("imem_addr", o_imem_addr, m_fpc);
      chk("valid", 64'(o_valid), 64'(exp_valid));
      if (exp_valid) begin
         chk("pc", o_pc, fbq[0].pc);
         chk("instr", 64'(o_instr), 64'(fbq[0].instr));
         if (!stall_v) begin
            chk("seq_pc", o_pc, seq_pc);
            seq_pc = seq_pc + 64'd4;
         end
      end else begin
         chk("idle_instr", 64'(o_instr), 64'(FETCH_NOP));
         chk("idle_pc", o_pc, 64'h0);
      end
      fire = exp_req && gnt_en;
      if (fire && first_gnt < 0) first_gnt = cyc;
      if (o_valid && first_valid < 0) first_valid = cyc;
      @(posedge clk);
      cyc++;
      if (!rst_v) begin
         m_fpc = RESET_PC; m_rpc = RESET_PC; seq_pc = RESET_PC;
         m_live = 0; m_drop = 0;
         fbq.delete(); mq_addr.delete(); mq_cyc.delete();
      end else if (redir_v) begin
         m_drop = m_drop + m_live + (fire ? 1 : 0) - (rv ? 1 : 0);
         m_live = 0;
         fbq.delete();
         m_fpc  = {redir_pc_v[63:2], 2'b00};
         m_rpc  = m_fpc;
         seq_pc = m_fpc;
         if (rv) begin void'(mq_addr.pop_front()); void'(mq_cyc.pop_front()); end
      end else begin
         if (exp_valid && !stall_v) void'(fbq.pop_front());
         if (rv) begin
            if (m_drop > 0) m_drop--;
            else begin
               fbq.push_back('{pc: m_rpc, instr: mem_word(rv_addr)});
               m_rpc = m_rpc + 64'd4;
               m_live--;
            end
            void'(mq_addr.pop_front()); void'(mq_cyc.pop_front());
         end
         if (fire) begin
            mq_addr.push_back(m_fpc);
            mq_cyc.push_back(cyc - 1);
            m_fpc = m_fpc + 64'd4;
            m_live++;
         end
      end
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      rst_v = 1'b0; stall_v = 1'b0; redir_v = 1'b0; gnt_en = 1'b1; rv_en = 1'b1;
      redir_pc_v = 64'h0;
      m_fpc = RESET_PC; m_rpc = RESET_PC; seq_pc = RESET_PC;
      m_live = 0; m_drop = 0;
      first_gnt = -1; first_valid = -1;
      rst_n = 1'b0; i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
      i_redirect = 1'b0; i_redirect_pc = '0; i_stall = 1'b0;

      run(3);
      // steady stream: 1-cycle imem, no stall
      rst_v = 1'b1;
      run(10);
      chk("gnt_to_valid", 64'(first_valid - first_gnt), 64'd2);

      // stall long enough to exhaust credits, then release
      stall_v = 1'b1; run(5);
      stall_v = 1'b0; run(6);

      // redirect with responses held back so requests are in flight
      rv_en = 1'b0; run(2);
      rv_en = 1'b1; redir_v = 1'b1; redir_pc_v = 64'h1002; run(1);
      redir_v = 1'b0; run(6);

      // redirect coincident with a response, then back-to-back redirects near the wrap
      redir_v = 1'b1; redir_pc_v = 64'h3000; run(1);
      redir_pc_v = 64'hFFFF_FFFF_FFFF_FFF8; run(1);
      redir_v = 1'b0; run(8);

      // grant withheld for three cycles
      redir_v = 1'b1; redir_pc_v = 64'h2000; run(1);
      redir_v = 1'b0; gnt_en = 1'b0; run(3);
      gnt_en = 1'b1; run(6);

      // reset mid-stream with a full buffer
      stall_v = 1'b1; run(5);
      rst_v = 1'b0; run(1);
      rst_v = 1'b1; stall_v = 1'b0; run(6);

      // randomized handshakes, stalls and redirects
      for (int i = 0; i < 300; i++) begin
         gnt_en     = ($urandom_range(0, 9) < 7);
         rv_en      = ($urandom_range(0, 9) < 6);
         stall_v    = ($urandom_range(0, 3) == 0);
         redir_v    = ($urandom_range(0, 19) == 0);
         redir_pc_v = {32'($urandom), 32'($urandom)};
         step();
      end
      gnt_en = 1'b1; rv_en = 1'b1; stall_v = 1'b0; redir_v = 1'b0;
      run(10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
